// File: rtl/loop_buf_pkg.sv
// loop_buf_pkg: definitions shared by the loop-buffer capture FSM and the
// replay unit (entry layout, address map, replay state encoding).
package loop_buf_pkg;

  // Address increment between consecutive stored entries (entry i at i*STRIDE)
  localparam int STRIDE = 8;

  // Longest loop body (in instructions) the buffer accepts
  localparam int MAX_ENTRIES = 8;

  // Width of a loop-length / entry-index field
  localparam int LEN_W = 4;

  // Opcodes of the loop-closing branch kinds the capture side recognises
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_BTYPE = 7'b1100011;

  // Replay sequencing: wait for a loop, fill the read pipe, stream, flush out
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_EXIT   = 2'd3
  } replay_state_t;

endpackage

// File: rtl/replay_index_ctr.sv
// replay_index_ctr: wrapping read pointer over the stored loop body plus a
// saturating count of completed iterations.
module replay_index_ctr
  import loop_buf_pkg::*;
#(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              count_en,
  input  logic [LEN_W-1:0]  len,
  output logic [LEN_W-1:0]  idx,
  output logic [LEN_W-1:0]  idx_next,
  output logic [ITER_W-1:0] iter_count
);

  logic at_last;

  assign at_last  = (idx == (len - LEN_W'(1)));
  assign idx_next = at_last ? '0 : (idx + LEN_W'(1));

  // Read pointer restarts at entry 0 for a new loop and steps with wrap on each advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx_next;
    end
  end

  // One iteration is counted each time the pointer wraps while streaming; sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_count <= '0;
    end else if (clear) begin
      iter_count <= '0;
    end else if (advance && count_en && at_last && (iter_count != '1)) begin
      iter_count <= iter_count + ITER_W'(1);
    end
  end

endmodule

// File: rtl/loop_replay_unit.sv
// loop_replay_unit: read side of the loop buffer. Streams a captured loop body
// from the uop cache to ID while fetch is blocked, wrapping until a mispredict,
// then flushes and hands fetch the fall-through PC.
module loop_replay_unit
  import loop_buf_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  loop_len,
  input  logic [31:0]       loop_start_pc,
  input  logic              bubble_idex,
  input  logic              mispredict,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  output logic [31:0]       out_instruction,
  output logic [31:0]       out_pc,
  output logic              block_signal,
  output logic              flush,
  output logic [31:0]       resume_pc,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_ENTRIES);

  replay_state_t    state, state_next;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      pc_q;
  logic [LEN_W-1:0] idx, idx_next;
  logic             accept;
  logic             advance;

  // A loop is taken only from IDLE and only with a length the buffer can hold
  assign accept = (state == ST_IDLE) && start &&
                  (loop_len != '0) && (loop_len <= MAX_LEN);

  // PRIME always moves the first entry into the output stage; STREAM moves only when ID is not stalled
  assign advance = !mispredict &&
                   ((state == ST_PRIME) || ((state == ST_STREAM) && !bubble_idex));

  assign resume_pc = pc_q + {{(32-LEN_W-2){1'b0}}, len_q, 2'b00};

  replay_index_ctr #(
    .ITER_W(ITER_W)
  ) u_index_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .advance   (advance),
    .count_en  (state == ST_STREAM),
    .len       (len_q),
    .idx       (idx),
    .idx_next  (idx_next),
    .iter_count(iter_count)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: mispredict wins over everything once a loop is in flight
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_PRIME;
      ST_PRIME:  state_next = mispredict ? ST_EXIT : ST_STREAM;
      ST_STREAM: if (mispredict) state_next = ST_EXIT;
      ST_EXIT:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs: the read for the next entry is issued in the same cycle the current one is consumed
  always_comb begin
    rd_en        = 1'b0;
    rd_addr      = '0;
    out_valid    = 1'b0;
    block_signal = 1'b0;
    flush        = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_en = accept;
      end
      ST_PRIME: begin
        block_signal = 1'b1;
        rd_en        = advance;
        rd_addr      = ADDR_W'(32'(idx_next) * STRIDE);
      end
      ST_STREAM: begin
        block_signal = 1'b1;
        out_valid    = 1'b1;
        rd_en        = advance;
        rd_addr      = ADDR_W'(32'(idx_next) * STRIDE);
      end
      ST_EXIT: begin
        flush = 1'b1;
      end
      default: begin
        flush = 1'b0;
      end
    endcase
  end

  // Loop length and start PC are captured once per accepted loop and kept for resume_pc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      pc_q  <= '0;
    end else if (accept) begin
      len_q <= loop_len;
      pc_q  <= loop_start_pc;
    end
  end

  // Output stage takes the entry currently on rd_data, tagged with its PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_instruction <= '0;
      out_pc          <= '0;
    end else if (advance) begin
      out_instruction <= rd_data;
      out_pc          <= pc_q + {{(32-LEN_W-2){1'b0}}, idx, 2'b00};
    end
  end

endmodule

// File: tb/tb_loop_replay_unit.sv
// tb_loop_replay_unit: directed and randomized checks of the loop replay unit
// against a behavioural model of the instruction stream seen by ID.
module tb_loop_replay_unit;

  localparam int TB_STRIDE = 8;

  typedef enum int {M_IDLE, M_PRIME, M_STREAM, M_EXIT} model_mode_t;

  logic        clk           = 1'b0;
  logic        reset         = 1'b0;
  logic        start         = 1'b0;
  logic [3:0]  loop_len      = 4'd0;
  logic [31:0] loop_start_pc = 32'd0;
  logic        bubble_idex   = 1'b0;
  logic        mispredict    = 1'b0;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data       = 32'd0;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        block_signal;
  logic        flush;
  logic [31:0] resume_pc;
  logic [15:0] iter_count;

  logic [31:0] mem [0:511];

  int check_count = 0;
  int error_count = 0;

  // Model: which instruction ID should see, and how many iterations are complete
  model_mode_t m_mode = M_IDLE;
  int          m_len  = 0;
  logic [31:0] m_pc   = 32'd0;
  int          m_o    = 0;
  int          m_iter = 0;

  always #5 clk = ~clk;

  loop_replay_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .loop_len       (loop_len),
    .loop_start_pc  (loop_start_pc),
    .bubble_idex    (bubble_idex),
    .mispredict     (mispredict),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .out_valid      (out_valid),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .block_signal   (block_signal),
    .flush          (flush),
    .resume_pc      (resume_pc),
    .iter_count     (iter_count)
  );

  // External uop cache: one-cycle read latency, output held while not reading
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then let the model take the edge
  task automatic applyStimulus(input logic st, input logic [3:0] ln, input logic [31:0] pc,
                               input logic bub, input logic mp);
    logic exp_rden;
    int   exp_addr;
    @(negedge clk);
    start         = st;
    loop_len      = ln;
    loop_start_pc = pc;
    bubble_idex   = bub;
    mispredict    = mp;
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_mode == M_STREAM));
    checkOutput("block_signal", 32'(block_signal), 32'(m_mode == M_PRIME || m_mode == M_STREAM));
    checkOutput("flush", 32'(flush), 32'(m_mode == M_EXIT));
    checkOutput("iter_count", 32'(iter_count), 32'(m_iter));
    if (m_mode == M_IDLE || m_mode == M_EXIT)
      checkOutput("resume_pc", resume_pc, m_pc + 32'(4 * m_len));
    if (m_mode == M_STREAM) begin
      checkOutput("out_pc", out_pc, m_pc + 32'(4 * m_o));
      checkOutput("out_instruction", out_instruction, mem[9'(m_o * TB_STRIDE)]);
    end
    exp_rden = 1'b0;
    exp_addr = 0;
    if (m_mode == M_IDLE && st && ln >= 4'd1 && ln <= 4'd8) begin
      exp_rden = 1'b1;
      exp_addr = 0;
    end else if (m_mode == M_PRIME && !mp) begin
      exp_rden = 1'b1;
      exp_addr = (1 % m_len) * TB_STRIDE;
    end else if (m_mode == M_STREAM && !mp && !bub) begin
      exp_rden = 1'b1;
      exp_addr = ((m_o + 2) % m_len) * TB_STRIDE;
    end
    checkOutput("rd_en", 32'(rd_en), 32'(exp_rden));
    if (exp_rden) checkOutput("rd_addr", 32'(rd_addr), 32'(exp_addr));
    @(posedge clk);
    case (m_mode)
      M_IDLE: begin
        if (st && ln >= 4'd1 && ln <= 4'd8) begin
          m_mode = M_PRIME;
          m_len  = 32'(ln);
          m_pc   = pc;
          m_iter = 0;
        end
      end
      M_PRIME: begin
        if (mp) m_mode = M_EXIT;
        else begin
          m_mode = M_STREAM;
          m_o    = 0;
        end
      end
      M_STREAM: begin
        if (mp) m_mode = M_EXIT;
        else if (!bub) begin
          m_o = (m_o + 1) % m_len;
          // An iteration is counted when the loop's closing instruction is handed to ID
          if (m_o == m_len - 1 && m_iter != 65535) m_iter++;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of whatever is running; everything must read zero
  task automatic pulseReset();
    @(negedge clk);
    start       = 1'b0;
    bubble_idex = 1'b0;
    mispredict  = 1'b0;
    reset       = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_block_signal", 32'(block_signal), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_iter_count", 32'(iter_count), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_instruction", out_instruction, 32'd0);
    checkOutput("rst_resume_pc", resume_pc, 32'd0);
    m_mode = M_IDLE;
    m_len  = 0;
    m_pc   = 32'd0;
    m_o    = 0;
    m_iter = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    pulseReset();

    // len=4 at 0x100, three wraps, then exit
    applyStimulus(1'b1, 4'd4, 32'h100, 1'b0, 1'b0);
    #1 checkOutput("prime_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    #1 checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_pc", out_pc, 32'h100);
    idleCycles(12);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    #1 checkOutput("exit_flush", 32'(flush), 32'd1);
    checkOutput("exit_iter_count", 32'(iter_count), 32'd3);
    checkOutput("exit_resume_pc", resume_pc, 32'h110);
    checkOutput("exit_block_drop", 32'(block_signal), 32'd0);
    idleCycles(2);
    #1 checkOutput("flush_one_cycle", 32'(flush), 32'd0);
    checkOutput("resume_held", resume_pc, 32'h110);

    // Three-cycle stall while 0x104 is on the output
    applyStimulus(1'b1, 4'd4, 32'h100, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    #1 checkOutput("stall_hold_pc", out_pc, 32'h104);
    checkOutput("stall_hold_instr", out_instruction, mem[9'd8]);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    #1 checkOutput("stall_resume_pc", out_pc, 32'h108);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
    idleCycles(2);

    // Out-of-range lengths are ignored
    applyStimulus(1'b1, 4'd0, 32'h300, 1'b0, 1'b0);
    #1 checkOutput("len0_block", 32'(block_signal), 32'd0);
    applyStimulus(1'b1, 4'd9, 32'h300, 1'b0, 1'b0);
    #1 checkOutput("len9_block", 32'(block_signal), 32'd0);
    idleCycles(2);

    // Mispredict while priming: no valid output ever, straight to exit
    applyStimulus(1'b1, 4'd3, 32'h400, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    #1 checkOutput("prime_exit_flush", 32'(flush), 32'd1);
    checkOutput("prime_exit_valid", 32'(out_valid), 32'd0);
    checkOutput("prime_exit_resume", resume_pc, 32'h40C);
    idleCycles(2);

    // start and mispredict together in IDLE: start wins
    applyStimulus(1'b1, 4'd2, 32'h500, 1'b0, 1'b1);
    idleCycles(5);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    idleCycles(2);

    // len=1 with toggling stall, then reset mid-stream
    applyStimulus(1'b1, 4'd1, 32'h200, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 4'd0, 32'd0, 1'(i % 2), 1'b0);
    #1 checkOutput("len1_pc", out_pc, 32'h200);
    pulseReset();
    idleCycles(2);

    // Randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      logic [3:0]  ln;
      logic [31:0] pc;
      int          run;
      if ($urandom_range(0, 7) == 0)
        ln = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      else
        ln = 4'($urandom_range(1, 8));
      if ($urandom_range(0, 4) == 0) pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7)) * 32'd4;
      else pc = $urandom & 32'h0000_FFFC;
      applyStimulus(1'b1, ln, pc, 1'b0, ($urandom_range(0, 9) == 0));
      run = $urandom_range(0, 30);
      for (int c = 0; c < run; c++)
        applyStimulus(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 9) < 3), 1'b0);
      if ($urandom_range(0, 9) == 0) pulseReset();
      else applyStimulus(1'b0, 4'd0, 32'd0, ($urandom_range(0, 1) == 1), 1'b1);
      idleCycles(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
